// File: rtl/cla_pipe_adder_if.sv
// Valid/ready operand and result bundle for cla_pipe_adder.
// Ports: in_valid/in_ready/op1/op2/cin/sub in; out_valid/out_ready/sum/cout/ovf out.
// Optional member sat_en exists only when CLA_SAT_EN is defined.
interface cla_pipe_adder_if #(
   parameter int WIDTH = 32
);
   logic             in_valid;
   logic             in_ready;
   logic [WIDTH-1:0] op1;
   logic [WIDTH-1:0] op2;
   logic             cin;
   logic             sub;
   logic             out_valid;
   logic             out_ready;
   logic [WIDTH-1:0] sum;
   logic             cout;
   logic             ovf;
`ifdef CLA_SAT_EN
   logic             sat_en;

   modport master (
      output in_valid, op1, op2, cin, sub, sat_en, out_ready,
      input  in_ready, out_valid, sum, cout, ovf
   );
   modport slave (
      input  in_valid, op1, op2, cin, sub, sat_en, out_ready,
      output in_ready, out_valid, sum, cout, ovf
   );
`else
   modport master (
      output in_valid, op1, op2, cin, sub, out_ready,
      input  in_ready, out_valid, sum, cout, ovf
   );
   modport slave (
      input  in_valid, op1, op2, cin, sub, out_ready,
      output in_ready, out_valid, sum, cout, ovf
   );
`endif
endinterface

// File: rtl/cla_pipe_adder.sv
// Pipelined carry-lookahead adder/subtractor built from 4-bit CLA groups.
// Ports: clk, rst_n (sync, active-low), bus (cla_pipe_adder_if.slave).
// Optional saturation on signed overflow when CLA_SAT_EN is defined.
module cla_pipe_adder #(
   parameter int WIDTH  = 32,
   parameter int STAGES = 2
) (
   input logic             clk,
   input logic             rst_n,
   cla_pipe_adder_if.slave bus
);
   localparam int G  = WIDTH / (4 * STAGES);
   localparam int SW = 4 * G;

   logic             stall;
   logic             adv;
   logic             vld_q;
   logic [WIDTH-1:0] sum_q;
   logic             cout_q;
   logic             ovf_q;

   assign stall         = vld_q & ~bus.out_ready;
   assign adv           = ~stall;
   assign bus.in_ready  = adv;
   assign bus.out_valid = vld_q;
   assign bus.sum       = sum_q;
   assign bus.cout      = cout_q;
   assign bus.ovf       = ovf_q;

   // Returns {c4, sum[3:0]} of one lookahead group.
   function automatic logic [4:0] cla4(
      input logic [3:0] a,
      input logic [3:0] b,
      input logic       c0
   );
      logic [3:0] g;
      logic [3:0] p;
      logic [4:0] c;
      g    = a & b;
      p    = a ^ b;
      c[0] = c0;
      c[1] = g[0] | (p[0] & c0);
      c[2] = g[1] | (p[1] & g[0]) | (p[1] & p[0] & c0);
      c[3] = g[2] | (p[2] & g[1]) | (p[2] & p[1] & g[0])
           | (p[2] & p[1] & p[0] & c0);
      c[4] = g[3] | (p[3] & g[2]) | (p[3] & p[2] & g[1])
           | (p[3] & p[2] & p[1] & g[0])
           | (p[3] & p[2] & p[1] & p[0] & c0);
      return {c[4], p ^ c[3:0]};
   endfunction

   for (genvar k = 0; k < STAGES; k++) begin : g_st
      // Operand bits still to be processed, stage k sees them at bit 0.
      localparam int RW = WIDTH - k * SW;

      logic [RW-1:0]         a_in;
      logic [RW-1:0]         b_in;
      logic                  c_in;
      logic                  v_in;
      logic [SW-1:0]         s_new;
      logic                  c_out;
      logic [(k+1)*SW-1:0]   s_full;
`ifdef CLA_SAT_EN
      logic                  sat_in;
`endif

      if (k == 0) begin : g_src
         assign a_in   = bus.op1;
         assign b_in   = bus.op2 ^ {WIDTH{bus.sub}};
         assign c_in   = bus.sub | bus.cin;
         assign v_in   = bus.in_valid;
         assign s_full = s_new;
`ifdef CLA_SAT_EN
         assign sat_in = bus.sat_en;
`endif
      end else begin : g_src
         assign a_in   = g_st[k-1].g_reg.a_q;
         assign b_in   = g_st[k-1].g_reg.b_q;
         assign c_in   = g_st[k-1].g_reg.c_q;
         assign v_in   = g_st[k-1].g_reg.v_q;
         assign s_full = {s_new, g_st[k-1].g_reg.s_q};
`ifdef CLA_SAT_EN
         assign sat_in = g_st[k-1].g_reg.sat_q;
`endif
      end

      // Group carries ripple through this stage's groups.
      always_comb begin : p_cla
         logic [4:0] r;
         logic       c;
         c     = c_in;
         r     = '0;
         s_new = '0;
         for (int j = 0; j < G; j++) begin
            r = cla4(a_in[j*4 +: 4], b_in[j*4 +: 4], c);
            s_new[j*4 +: 4] = r[3:0];
            c = r[4];
         end
         c_out = c;
      end

      if (k < STAGES - 1) begin : g_reg
         logic [RW-SW-1:0]    a_q;
         logic [RW-SW-1:0]    b_q;
         logic [(k+1)*SW-1:0] s_q;
         logic                c_q;
         logic                v_q;
`ifdef CLA_SAT_EN
         logic                sat_q;
`endif
         always_ff @(posedge clk) begin
            if (!rst_n) begin
               a_q <= '0;
               b_q <= '0;
               s_q <= '0;
               c_q <= 1'b0;
               v_q <= 1'b0;
`ifdef CLA_SAT_EN
               sat_q <= 1'b0;
`endif
            end else if (adv) begin
               a_q <= a_in[RW-1:SW];
               b_q <= b_in[RW-1:SW];
               s_q <= s_full;
               c_q <= c_out;
               v_q <= v_in;
`ifdef CLA_SAT_EN
               sat_q <= sat_in;
`endif
            end
         end
      end else begin : g_out
         logic [WIDTH-1:0] res;
         logic             ovf_c;

         // Carry into the MSB is recovered as s ^ a ^ b at that bit.
         always_comb begin
            ovf_c = s_new[SW-1] ^ a_in[SW-1] ^ b_in[SW-1] ^ c_out;
            res   = s_full;
`ifdef CLA_SAT_EN
            if (sat_in && ovf_c)
               res = a_in[SW-1] ? {1'b1, {(WIDTH-1){1'b0}}}
                                : {1'b0, {(WIDTH-1){1'b1}}};
`endif
         end

         always_ff @(posedge clk) begin
            if (!rst_n) begin
               vld_q  <= 1'b0;
               sum_q  <= '0;
               cout_q <= 1'b0;
               ovf_q  <= 1'b0;
            end else if (adv) begin
               vld_q  <= v_in;
               sum_q  <= res;
               cout_q <= c_out;
               ovf_q  <= ovf_c;
            end
         end
      end
   end
endmodule

// File: tb/tb_cla_pipe_adder.sv
// Self-checking bench for cla_pipe_adder: directed vector table plus
// backpressure, reset-flush and latency sequences.
module tb_cla_pipe_adder;
   localparam int WIDTH = 32;
   parameter int STAGES = 2;

   logic clk = 1'b0;
   logic rst_n = 1'b0;
   always #5 clk = ~clk;

   cla_pipe_adder_if #(.WIDTH(WIDTH)) bus ();

   cla_pipe_adder #(
      .WIDTH (WIDTH),
      .STAGES(STAGES)
   ) dut (
      .clk  (clk),
      .rst_n(rst_n),
      .bus  (bus)
   );

   int checks = 0;
   int errors = 0;

   typedef struct {
      logic [31:0] a;
      logic [31:0] b;
      logic        cin;
      logic        sub;
      logic        sat;
      logic [31:0] s;
      logic        co;
      logic        ov;
   } vec_t;

   vec_t tbl[12];

   task automatic chk(input string nm, input logic [63:0] got,
                      input logic [63:0] exp);
      checks++;
      if (got !== exp) begin
         errors++;
         $display("FAIL %s got %h expected %h", nm, got, exp);
      end
   endtask

   task automatic drive(input vec_t v);
      bus.op1 = v.a;
      bus.op2 = v.b;
      bus.cin = v.cin;
      bus.sub = v.sub;
`ifdef CLA_SAT_EN
      bus.sat_en = v.sat;
`endif
   endtask

   task automatic run_one(input vec_t v, input string nm);
      int lat;
      bit seen;
      @(negedge clk);
      drive(v);
      bus.in_valid  = 1'b1;
      bus.out_ready = 1'b1;
      #1;
      chk({nm, "_in_ready"}, 64'(bus.in_ready), 64'(1));
      @(posedge clk);
      #1;
      bus.in_valid = 1'b0;
      lat  = 1;
      seen = 1'b0;
      while (!seen && lat <= STAGES + 4) begin
         if (bus.out_valid) seen = 1'b1;
         else begin
            @(posedge clk);
            #1;
            lat++;
         end
      end
      chk({nm, "_latency"}, 64'(lat), 64'(STAGES));
      if (seen) begin
         chk({nm, "_sum"}, 64'(bus.sum), 64'(v.s));
         chk({nm, "_cout"}, 64'(bus.cout), 64'(v.co));
         chk({nm, "_ovf"}, 64'(bus.ovf), 64'(v.ov));
      end
      @(posedge clk);
   endtask

   initial begin
      vec_t v;
      bit pat[4];
      int sent;
      int rcv;
      int cyc;
      int seen;
      bit hold;
      logic [31:0] hold_s;

      tbl[0]  = '{32'h0000_0005, 32'h0000_0003, 1'b1, 1'b0, 1'b0,
                  32'h0000_0009, 1'b0, 1'b0};
      tbl[1]  = '{32'h0000_FFFF, 32'h0000_0001, 1'b0, 1'b0, 1'b0,
                  32'h0001_0000, 1'b0, 1'b0};
      tbl[2]  = '{32'hFFFF_FFFF, 32'h0000_0001, 1'b0, 1'b0, 1'b0,
                  32'h0000_0000, 1'b1, 1'b0};
      tbl[3]  = '{32'h0000_0003, 32'h0000_0005, 1'b0, 1'b1, 1'b0,
                  32'hFFFF_FFFE, 1'b0, 1'b0};
      tbl[4]  = '{32'h8000_0000, 32'h0000_0001, 1'b0, 1'b1, 1'b0,
                  32'h7FFF_FFFF, 1'b1, 1'b1};
      tbl[5]  = '{32'h7FFF_FFFF, 32'h0000_0001, 1'b0, 1'b0, 1'b0,
                  32'h8000_0000, 1'b0, 1'b1};
      tbl[6]  = '{32'h0000_0005, 32'h0000_0005, 1'b0, 1'b1, 1'b0,
                  32'h0000_0000, 1'b1, 1'b0};
      tbl[7]  = '{32'h1234_5678, 32'h9ABC_DEF0, 1'b0, 1'b0, 1'b0,
                  32'hACF1_3568, 1'b0, 1'b0};
      tbl[8]  = '{32'h8000_0000, 32'h8000_0000, 1'b0, 1'b0, 1'b0,
                  32'h0000_0000, 1'b1, 1'b1};
      tbl[9]  = '{32'h0000_000A, 32'h0000_0003, 1'b1, 1'b1, 1'b0,
                  32'h0000_0007, 1'b1, 1'b0};
      tbl[10] = '{32'hFFFF_FFFF, 32'hFFFF_FFFF, 1'b1, 1'b0, 1'b0,
                  32'hFFFF_FFFF, 1'b1, 1'b0};
      tbl[11] = '{32'h0FFF_FFFF, 32'h0000_0001, 1'b0, 1'b0, 1'b0,
                  32'h1000_0000, 1'b0, 1'b0};

      // Reset: beats presented during reset are discarded.
      drive(tbl[0]);
      bus.in_valid  = 1'b1;
      bus.out_ready = 1'b1;
      repeat (2) begin
         @(posedge clk);
         #1;
         chk("rst_valid", 64'(bus.out_valid), 64'(0));
         chk("rst_sum", 64'(bus.sum), 64'(0));
         chk("rst_cout", 64'(bus.cout), 64'(0));
         chk("rst_ovf", 64'(bus.ovf), 64'(0));
      end
      @(negedge clk);
      rst_n = 1'b1;
      bus.in_valid = 1'b0;

      for (int i = 0; i < 12; i++)
         run_one(tbl[i], $sformatf("vec%0d", i));

`ifdef CLA_SAT_EN
      v = '{32'h8000_0000, 32'h0000_0001, 1'b0, 1'b1, 1'b1,
            32'h8000_0000, 1'b1, 1'b1};
      run_one(v, "sat_neg");
      v = '{32'h7FFF_FFFF, 32'h0000_0001, 1'b0, 1'b0, 1'b1,
            32'h7FFF_FFFF, 1'b0, 1'b1};
      run_one(v, "sat_pos");
      v = '{32'h0000_0005, 32'h0000_0003, 1'b1, 1'b0, 1'b1,
            32'h0000_0009, 1'b0, 1'b0};
      run_one(v, "sat_noovf");
`endif

      // Backpressure stream.
      pat    = '{1'b1, 1'b0, 1'b0, 1'b1};
      sent   = 0;
      rcv    = 0;
      cyc    = 0;
      hold   = 1'b0;
      hold_s = '0;
      v = tbl[0];
      v.cin = 1'b0;
      v.sat = 1'b0;
      while (rcv < 8 && cyc < 200) begin
         @(negedge clk);
         v.a = 32'(sent);
         v.b = 32'(sent);
         drive(v);
         bus.out_ready = pat[cyc % 4];
         bus.in_valid  = (sent < 8);
         #1;
         if (hold) begin
            chk("bp_hold_valid", 64'(bus.out_valid), 64'(1));
            chk("bp_hold_sum", 64'(bus.sum), 64'(hold_s));
         end
         chk("bp_in_ready", 64'(bus.in_ready),
             64'(!(bus.out_valid && !bus.out_ready)));
         if (bus.out_valid && bus.out_ready) begin
            chk("bp_sum", 64'(bus.sum), 64'(2 * rcv));
            rcv++;
         end
         hold   = bus.out_valid && !bus.out_ready;
         hold_s = bus.sum;
         if (bus.in_valid && bus.in_ready) sent++;
         cyc++;
      end
      chk("bp_count", 64'(rcv), 64'(8));

      // Reset mid-flight: held beats are flushed and never emitted.
      v.a = 32'd100;
      v.b = 32'd200;
      repeat (2) begin
         @(negedge clk);
         drive(v);
         bus.in_valid  = 1'b1;
         bus.out_ready = 1'b0;
         v.a = v.a + 32'd1;
      end
      @(negedge clk);
      rst_n = 1'b0;
      @(posedge clk);
      #1;
      chk("flush_valid", 64'(bus.out_valid), 64'(0));
      chk("flush_sum", 64'(bus.sum), 64'(0));
      @(negedge clk);
      rst_n = 1'b1;
      bus.in_valid  = 1'b0;
      bus.out_ready = 1'b1;
      seen = 0;
      repeat (3 * STAGES + 4) begin
         @(posedge clk);
         #1;
         if (bus.out_valid) seen++;
      end
      chk("flush_none", 64'(seen), 64'(0));

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end
endmodule
